fmap_writer: RTL and testbench
==============================

Name: fmap_writer

Overview:
- Write-side counterpart of the layer feature-map loader.
- Accepts the serial stream of 32-bit PE convolution results over a valid/ready handshake.
- Requantizes each result to 8 bits (ReLU, arithmetic shift, saturation) and stores it row-major into an internal IMG_W x IMG_W byte buffer.
- Exposes a synchronous read port so the next layer's loader can fetch the stored feature map; signals completion with done.

Parameters:
- IMG_W, 13, side length of the output feature map (buffer holds IMG_W*IMG_W bytes; 169 by default).
- DATA_W, 32, width of the incoming signed PE result.
- SHIFT, 8, right-shift applied before saturation (fixed-point rescale).

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, begins a new frame capture; sampled in IDLE and DONE only.
- in_valid, input, 1, in_data carries a PE result.
- in_data, input, DATA_W, signed two's-complement PE result.
- in_ready, output, 1, writer accepts a result this cycle.
- rd_addr, input, 8, byte address into the buffer for the read port.
- rd_data, output, 8, buffer byte at rd_addr from the previous cycle.
- count, output, 8, number of results accepted in the current frame.
- busy, output, 1, high in WRITE state.
- done, output, 1, high in DONE state (level, not pulse).

Behaviour:
- Reset, asynchronous: state=IDLE, count=0, wr address=0, in_ready=0, busy=0, done=0, rd_data=0. Buffer contents are not cleared.
- States:
  - IDLE: start=1 -> WRITE with address and count cleared.
  - WRITE: in_ready=1, busy=1. A handshake (in_valid & in_ready) writes q(in_data) to buf[addr], then addr++ and count++. The handshake at addr = IMG_W*IMG_W-1 -> DONE.
  - DONE: done=1, in_ready=0. start=1 -> WRITE with address and count cleared and done dropped the next cycle; otherwise stay in DONE.
- in_ready is a registered function of state only. It is never gated by in_valid.
- Input gaps: in_valid low in WRITE stalls; no write occurs and address and count hold.
- in_valid while in IDLE or DONE: ignored (in_ready=0). No write and no count change.
- start in WRITE: ignored. The frame continues to completion.
- Quantization q(x), all signed:
  - s = x >>> SHIFT (arithmetic shift, truncation, no rounding).
  - If s < 0, q = 0.
  - Else if s > 255, q = 255.
  - Else q = s[7:0].
- Write latency: the byte is in the buffer at the rising edge of the handshake cycle. A read issued the following cycle returns it.
- Read port:
  - Always active in every state.
  - rd_data is registered from buf[rd_addr] at each rising edge (1-cycle latency).
  - rd_addr >= IMG_W*IMG_W returns 0.
  - A read and a write to the same address in the same cycle return the old data.
- count saturates naturally at IMG_W*IMG_W. It is reset to 0 only by rst or a new start.
- Reset mid-frame: the state machine returns to IDLE immediately and count=0. Partially written bytes remain in the buffer. A later start overwrites the buffer from address 0.
- Single cycle between last handshake and done: done asserts on the edge after the final handshake. No extra flush cycles.

Test Plan:
- Full frame:
  - Stimulus: rst pulse, start, then 169 back-to-back results in_data = i<<8 for i = 0..168.
  - Required: done rises on the cycle after the 169th handshake; count=169; in_ready=0 afterwards.
  - Readback: reading addresses 0..168 returns i & 0xFF saturated (values 0..168).
- Quantization corners, SHIFT=8:
  - 0x00001234 -> 0x12.
  - 0x0000FFFF -> 0xFF.
  - 0x00FF0000 -> 255 (saturated).
  - 0xFFFFFF00 -> 0.
  - 0x80000000 -> 0.
  - 0x000000FF -> 0.
- Backpressure/gaps:
  - Stimulus: in_valid toggles 1,0,0,1 pattern with random gaps.
  - Required: count increments only on handshakes; stored sequence has no duplicates or holes; done only after the 169th accepted word.
- Reset mid-frame:
  - Stimulus: assert rst asynchronously after 50 writes.
  - Required: immediately busy=0, in_ready=0, count=0, done=0.
  - Then start and 169 new values: buffer fully reflects the new frame.
- Ignored inputs:
  - Stimulus: in_valid=1 with data 0x7F00 while in IDLE and DONE, plus start pulsed during WRITE.
  - Required: no buffer change, count unchanged, frame not restarted.
- Restart and read-during-write:
  - Stimulus: start in DONE begins a second frame; hold rd_addr=0 while writing address 0 with 0x0500.
  - Required: same-cycle read returns the old byte; next cycle returns 0x05.

Source files
------------

// File: rtl/fmap_writer.sv
// -----------------------------------------------------------------------------
// fmap_writer
//   Write-side companion of the layer feature-map loader. Accepts a serial
//   stream of signed PE convolution results over a valid/ready handshake,
//   requantizes each to an unsigned byte (ReLU, arithmetic right shift,
//   saturation to 255) and stores it row-major into an IMG_W x IMG_W byte
//   buffer. A synchronous read port lets the next layer fetch the stored map.
//
// Ports
//   clk       in   system clock, all state updates on the rising edge
//   rst       in   asynchronous active-high reset
//   start     in   begin a new frame capture (honoured in IDLE and DONE only)
//   in_valid  in   in_data carries a PE result
//   in_data   in   DATA_W signed two's-complement PE result
//   in_ready  out  writer accepts a result this cycle (registered, state only)
//   rd_addr   in   byte address for the read port
//   rd_data   out  buffer byte at rd_addr of the previous cycle (0 if out of range)
//   count     out  number of results accepted in the current frame
//   busy      out  high while capturing a frame (WRITE)
//   done      out  high once the frame is complete (DONE, level)
//
// Note: address/count are 8 bits wide, so IMG_W*IMG_W must not exceed 255.
// -----------------------------------------------------------------------------
module fmap_writer #(
  parameter int IMG_W  = 13,
  parameter int DATA_W = 32,
  parameter int SHIFT  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [7:0]        rd_addr,
  output logic [7:0]        rd_data,
  output logic [7:0]        count,
  output logic              busy,
  output logic              done
);

  localparam int         DEPTH     = IMG_W * IMG_W;
  localparam logic [7:0] LAST_ADDR = 8'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Requantize a signed PE result: arithmetic shift (truncating), clamp
  // negatives to 0 and anything above 255 to 255.
  function automatic logic [7:0] requant(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] s;
    s = $signed(x) >>> SHIFT;
    if (s[DATA_W-1]) begin
      requant = 8'h00;
    end else if (|s[DATA_W-2:8]) begin
      requant = 8'hFF;
    end else begin
      requant = s[7:0];
    end
  endfunction

  state_t     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] count_q, count_d;
  logic       in_ready_q, in_ready_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       wr_en_s;
  logic [7:0] wr_data_s;

  logic [7:0] mem [0:DEPTH-1];

  // Next-state, write strobe and registered-output inputs.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    count_d   = count_q;
    wr_en_s   = 1'b0;
    wr_data_s = requant(in_data);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WRITE;
          addr_d  = 8'd0;
          count_d = 8'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        // start is deliberately ignored here: a frame always runs to the end.
        if (in_valid && in_ready_q) begin
          wr_en_s = 1'b1;
          addr_d  = addr_q + 8'd1;
          count_d = count_q + 8'd1;
          if (addr_q == LAST_ADDR) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WRITE;
          end
        end else begin
          state_d = S_WRITE;
        end
      end
      S_DONE: begin
        if (start) begin
          state_d = S_WRITE;
          addr_d  = 8'd0;
          count_d = 8'd0;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status flags are registered copies of the upcoming state, so they
    // depend on state only and never on in_valid.
    in_ready_d = (state_d == S_WRITE);
    busy_d     = (state_d == S_WRITE);
    done_d     = (state_d == S_DONE);
  end

  // Read port mux: out-of-range addresses read as zero.
  always_comb begin
    if (rd_addr <= LAST_ADDR) begin
      rd_data_d = mem[rd_addr];
    end else begin
      rd_data_d = 8'h00;
    end
  end

  // Control and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= 8'd0;
      count_q    <= 8'd0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Feature-map storage; never reset, so partial frames survive a reset.
  // A same-cycle read of the written address sees the old byte.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem[addr_q] <= wr_data_s;
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign count    = count_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_fmap_writer.sv
module tb_fmap_writer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic [7:0]  rd_addr;
  logic [7:0]  rd_data;
  logic [7:0]  count;
  logic        busy;
  logic        done;

  int checks;
  int errors;

  logic [7:0] model_mem [0:168];
  int         model_addr;
  int         model_count;

  logic [7:0] exp_q [$];
  int         exp_addr_q [$];
  logic       rd_req;
  logic       rd_vld;

  fmap_writer #(.IMG_W(13), .DATA_W(32), .SHIFT(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_ready(in_ready),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .count   (count),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A read issued at an edge produces rd_data valid for the following cycle.
  always @(posedge clk) rd_vld <= rd_req;

  // Scoreboard monitor: pop the expected byte whenever a read result is due.
  always @(negedge clk) begin
    if (rd_vld === 1'b1) begin
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL rd_unexpected got %0h with empty scoreboard", rd_data);
      end else begin
        logic [7:0] e;
        int a;
        e = exp_q.pop_front();
        a = exp_addr_q.pop_front();
        if (rd_data !== e) begin
          errors = errors + 1;
          $display("FAIL rd_data addr=%0d got %0h want %0h", a, rd_data, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] qmodel(input logic [31:0] x);
    int v;
    int s;
    v = $signed(x);
    s = v >>> 8;
    if (s < 0) return 8'h00;
    else if (s > 255) return 8'hFF;
    else return 8'(s);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks = checks + 1;
    if (got !== want) begin
      errors = errors + 1;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    align();
    start = 1'b0;
    model_addr  = 0;
    model_count = 0;
  endtask

  // Offer one word; called at posedge+1, returns at posedge+1 after the handshake.
  task automatic send(input logic [31:0] x);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = x;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL send_timeout in_ready got %0b want 1", in_ready);
    end else begin
      @(posedge clk);
      model_mem[model_addr] = qmodel(x);
      model_addr++;
      model_count++;
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic rd(input int a, input logic [7:0] e);
    rd_addr = 8'(a);
    rd_req  = 1'b1;
    exp_q.push_back(e);
    exp_addr_q.push_back(a);
    align();
    rd_req = 1'b0;
  endtask

  task automatic drain();
    repeat (3) align();
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
  endtask

  logic [31:0] cv [0:5];
  logic [7:0]  ce [0:5];
  int          gap_tbl [0:3];

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 32'd0;
    rd_addr = 8'd0; rd_req = 1'b0;
    model_addr = 0; model_count = 0;
    for (int i = 0; i < 169; i++) model_mem[i] = 8'h00;
    cv[0] = 32'h00001234; ce[0] = 8'h12;
    cv[1] = 32'h0000FFFF; ce[1] = 8'hFF;
    cv[2] = 32'h00FF0000; ce[2] = 8'hFF;
    cv[3] = 32'hFFFFFF00; ce[3] = 8'h00;
    cv[4] = 32'h80000000; ce[4] = 8'h00;
    cv[5] = 32'h000000FF; ce[5] = 8'h00;
    gap_tbl[0] = 0; gap_tbl[1] = 2; gap_tbl[2] = 0; gap_tbl[3] = 1;

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_rd_data", 32'(rd_data), 32'd0);
    align();

    // in_valid in IDLE is ignored
    in_valid = 1'b1; in_data = 32'h7F00;
    repeat (3) align();
    in_valid = 1'b0;
    chk("idle_ignore_count", 32'(count), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Full frame, with a start pulse during WRITE that must be ignored
    pulse_start();
    chk("write_busy", 32'(busy), 32'd1);
    chk("write_in_ready", 32'(in_ready), 32'd1);
    chk("write_done", 32'(done), 32'd0);
    for (int i = 0; i < 169; i++) begin
      if (i == 168) chk("done_before_last", 32'(done), 32'd0);
      if (i == 80) start = 1'b1;
      send(32'(i) << 8);
      start = 1'b0;
      if (i == 80) begin
        chk("start_in_write_count", 32'(count), 32'd81);
        chk("start_in_write_busy", 32'(busy), 32'd1);
      end
    end
    chk("frame_done", 32'(done), 32'd1);
    chk("frame_count", 32'(count), 32'd169);
    chk("frame_in_ready", 32'(in_ready), 32'd0);
    chk("frame_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 169; i++) rd(i, 8'(i));
    rd(169, 8'h00);
    rd(255, 8'h00);
    drain();

    // in_valid in DONE is ignored
    in_valid = 1'b1; in_data = 32'h7F00;
    repeat (4) align();
    in_valid = 1'b0;
    chk("done_ignore_count", 32'(count), 32'd169);
    chk("done_hold", 32'(done), 32'd1);
    rd(0, 8'h00);
    rd(168, 8'd168);
    drain();

    // Restart from DONE, read-during-write at address 0
    pulse_start();
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    chk("restart_count", 32'(count), 32'd0);
    rd_addr = 8'd0;
    rd_req  = 1'b1;
    exp_q.push_back(8'h00); exp_addr_q.push_back(0);
    send(32'h0500);
    exp_q.push_back(8'h05); exp_addr_q.push_back(0);
    align();
    rd_req = 1'b0;
    drain();

    // Quantization corners at addresses 1..6
    for (int k = 0; k < 6; k++) send(cv[k]);
    chk("corner_count", 32'(count), 32'd7);

    // Remaining words with stalls between handshakes
    for (int i = 7; i < 169; i++) begin
      int g;
      logic [31:0] x;
      g = gap_tbl[i % 4] + int'($urandom_range(0, 2));
      repeat (g) align();
      chk("gap_count_hold", 32'(count), 32'(model_count));
      x = 32'(i * 911) << 3;
      if (i % 5 == 0) x = ~x;
      if (i == 168) chk("gap_done_before_last", 32'(done), 32'd0);
      send(x);
    end
    chk("gap_frame_done", 32'(done), 32'd1);
    chk("gap_frame_count", 32'(count), 32'd169);
    rd(0, 8'h05);
    for (int k = 0; k < 6; k++) rd(k + 1, ce[k]);
    for (int i = 7; i < 169; i++) rd(i, model_mem[i]);
    drain();

    // Reset mid-frame after 50 writes
    pulse_start();
    for (int i = 0; i < 50; i++) send(32'h3300 + (32'(i) << 8));
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_rd_data", 32'(rd_data), 32'd0);
    align();
    rst = 1'b0;
    for (int i = 0; i < 50; i++) rd(i, 8'(8'h33 + i));
    for (int i = 50; i < 169; i++) rd(i, model_mem[i]);
    drain();

    // New full frame after reset overwrites everything
    pulse_start();
    for (int i = 0; i < 169; i++) send((32'(168 - i) << 8) + 32'h80);
    chk("final_done", 32'(done), 32'd1);
    chk("final_count", 32'(count), 32'd169);
    for (int i = 0; i < 169; i++) rd(i, 8'(168 - i));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
